// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU status/branch logic:
//   - ALU control codes (gin) and a legality check for them
//   - branch-condition select encodings
//   - packed Z/N/V status record
// -----------------------------------------------------------------------------
package alu_pkg;

  // ALU control codes. Codes 3'b100 and 3'b101 are undefined.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    BR_NEVER  = 3'b000,
    BR_EQ     = 3'b001,  // live zout
    BR_NE     = 3'b010,  // live ~zout
    BR_Z      = 3'b011,  // stored Z
    BR_N      = 3'b100,  // stored N
    BR_V      = 3'b101,  // stored V
    BR_NZ     = 3'b110,  // stored ~Z
    BR_ALWAYS = 3'b111
  } br_cond_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } status_t;

  function automatic logic gin_legal(input logic [2:0] gin);
    logic ok;
    ok = 1'b0;
    case (gin)
      ALU_AND, ALU_OR, ALU_ADD, ALU_NOR, ALU_SUB, ALU_SLT: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_status_unit_if.sv
// -----------------------------------------------------------------------------
// alu_status_unit_if
// Bundles the ALU-side inputs and status/branch outputs of alu_status_unit.
//   master: upstream datapath (drives instruction/flag inputs, reads status)
//   slave : alu_status_unit itself
// -----------------------------------------------------------------------------
interface alu_status_unit_if #(
  parameter int CNT_W = 8
);
  logic             instr_valid;
  logic [2:0]       gin;
  logic             zout;
  logic             nout;
  logic             vout;
  logic             flag_we;
  logic             br_en;
  logic [2:0]       br_cond;
  logic             stat_clr;
  logic             z_flag;
  logic             n_flag;
  logic             v_flag;
  logic             v_sticky;
  logic [CNT_W-1:0] ovf_count;
  logic             op_err;
  logic             take_branch;

  modport master (
    output instr_valid, gin, zout, nout, vout, flag_we, br_en, br_cond, stat_clr,
    input  z_flag, n_flag, v_flag, v_sticky, ovf_count, op_err, take_branch
  );

  modport slave (
    input  instr_valid, gin, zout, nout, vout, flag_we, br_en, br_cond, stat_clr,
    output z_flag, n_flag, v_flag, v_sticky, ovf_count, op_err, take_branch
  );
endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk     : clock
//   reset   : synchronous active-high reset
//   inc     : count up by one (ignored when saturated)
//   clr     : zero the count; wins over inc
//   count_o : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (clr)                        count_d = '0;
    else if (inc && count_q != '1)  count_d = count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/alu_status_unit.sv
// -----------------------------------------------------------------------------
// alu_status_unit
// Status register, overflow bookkeeping and branch resolution downstream of
// the ALU.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset, overrides everything
//   bus   : slave side of alu_status_unit_if
//     inputs : instr_valid, gin, zout/nout/vout, flag_we, br_en, br_cond, stat_clr
//     outputs: z/n/v_flag (stored), v_sticky, ovf_count, op_err (registered),
//              take_branch (combinational)
// -----------------------------------------------------------------------------
module alu_status_unit
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  alu_status_unit_if.slave bus
);
  status_t          status_q, status_d;
  logic             v_sticky_q, v_sticky_d;
  logic             op_err_q, op_err_d;
  logic             upd, bad, ev;
  logic             cond;
  logic [CNT_W-1:0] ovf_count;

  assign upd = bus.instr_valid & bus.flag_we &  gin_legal(bus.gin);
  assign bad = bus.instr_valid & bus.flag_we & ~gin_legal(bus.gin);
  assign ev  = upd & bus.vout;

  always_comb begin
    status_d   = status_q;
    v_sticky_d = v_sticky_q;
    op_err_d   = op_err_q;
    if (upd) status_d = '{z: bus.zout, n: bus.nout, v: bus.vout};
    // Clear wins over a same-cycle set.
    if (bus.stat_clr)  v_sticky_d = 1'b0;
    else if (ev)       v_sticky_d = 1'b1;
    if (bus.stat_clr)  op_err_d = 1'b0;
    else if (bad)      op_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= '0;
      v_sticky_q <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      status_q   <= status_d;
      v_sticky_q <= v_sticky_d;
      op_err_q   <= op_err_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_ovf_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (ev),
    .clr     (bus.stat_clr),
    .count_o (ovf_count)
  );

  // Stored-flag conditions read status_q, i.e. the value before any update
  // committing at this edge.
  always_comb begin
    cond = 1'b0;
    case (br_cond_e'(bus.br_cond))
      BR_NEVER:  cond = 1'b0;
      BR_EQ:     cond = bus.zout;
      BR_NE:     cond = ~bus.zout;
      BR_Z:      cond = status_q.z;
      BR_N:      cond = status_q.n;
      BR_V:      cond = status_q.v;
      BR_NZ:     cond = ~status_q.z;
      BR_ALWAYS: cond = 1'b1;
    endcase
  end

  assign bus.take_branch = ~reset & bus.instr_valid & bus.br_en & cond;
  assign bus.z_flag      = status_q.z;
  assign bus.n_flag      = status_q.n;
  assign bus.v_flag      = status_q.v;
  assign bus.v_sticky    = v_sticky_q;
  assign bus.ovf_count   = ovf_count;
  assign bus.op_err      = op_err_q;
endmodule

// File: tb/tb_alu_status_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_status_unit
// Directed bench for alu_status_unit with a 2-bit overflow counter so that
// saturation is reached quickly. Inputs change 1 ns after a rising edge;
// registered outputs are sampled 1 ns after the edge, take_branch 1 ns after
// the inputs settle.
// -----------------------------------------------------------------------------
module tb_alu_status_unit;
  import alu_pkg::*;

  localparam int CNT_W = 2;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  alu_status_unit_if #(.CNT_W(CNT_W)) bus ();

  alu_status_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs,
                           input logic [CNT_W-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    bus.gin         = ALU_ADD;
    bus.zout        = 1'b0;
    bus.nout        = 1'b0;
    bus.vout        = 1'b0;
    bus.flag_we     = 1'b0;
    bus.br_en       = 1'b0;
    bus.br_cond     = BR_NEVER;
    bus.stat_clr    = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic z, input logic n,
                             input logic v, input logic vs,
                             input logic [CNT_W-1:0] cnt, input logic err);
    check_bit({tag, ".z"},   bus.z_flag,    z);
    check_bit({tag, ".n"},   bus.n_flag,    n);
    check_bit({tag, ".v"},   bus.v_flag,    v);
    check_bit({tag, ".vs"},  bus.v_sticky,  vs);
    check_cnt({tag, ".cnt"}, bus.ovf_count, cnt);
    check_bit({tag, ".err"}, bus.op_err,    err);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle();
    // Reset with an always-branch presented: take_branch must stay low.
    bus.instr_valid = 1'b1;
    bus.br_en       = 1'b1;
    bus.br_cond     = BR_ALWAYS;
    tick();
    tick();
    check_bit("rst_take", bus.take_branch, 1'b0);
    check_state("rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    // 1: SUB producing zero -> Z=1 next cycle; then BZ taken.
    reset = 1'b0;
    idle();
    bus.instr_valid = 1'b1;
    bus.flag_we     = 1'b1;
    bus.gin         = ALU_SUB;
    bus.zout        = 1'b1;
    tick();
    check_state("t1", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    bus.flag_we = 1'b0;
    bus.zout    = 1'b0;
    bus.br_en   = 1'b1;
    bus.br_cond = BR_Z;       #1 check_bit("t1_bz",  bus.take_branch, 1'b1);
    bus.br_cond = BR_NZ;      #1 check_bit("t1_bnz", bus.take_branch, 1'b0);
    bus.br_cond = BR_N;       #1 check_bit("t1_bn",  bus.take_branch, 1'b0);
    bus.br_cond = BR_EQ;      #1 check_bit("t1_beq", bus.take_branch, 1'b0);
    bus.br_cond = BR_NE;      #1 check_bit("t1_bne", bus.take_branch, 1'b1);
    bus.br_cond = BR_NEVER;   #1 check_bit("t1_nev", bus.take_branch, 1'b0);
    bus.br_en   = 1'b0;
    bus.br_cond = BR_ALWAYS;  #1 check_bit("t1_noen", bus.take_branch, 1'b0);

    // 2: flag write and stored-Z branch in the same cycle see the old Z.
    bus.flag_we = 1'b1;
    bus.gin     = ALU_ADD;
    bus.zout    = 1'b0;
    bus.nout    = 1'b1;
    bus.br_en   = 1'b1;
    bus.br_cond = BR_Z;
    #1 check_bit("t2_old_z", bus.take_branch, 1'b1);
    tick();
    check_state("t2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    bus.flag_we = 1'b0;
    bus.br_cond = BR_N;       #1 check_bit("t2_bn", bus.take_branch, 1'b1);

    // 3: overflow events saturate a 2-bit counter at 3.
    bus.br_en   = 1'b0;
    bus.flag_we = 1'b1;
    bus.gin     = ALU_ADD;
    bus.nout    = 1'b0;
    bus.vout    = 1'b1;
    tick(); check_state("t3_1", 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    tick(); check_cnt("t3_2", bus.ovf_count, 2'd2);
    tick(); check_cnt("t3_3", bus.ovf_count, 2'd3);
    tick(); check_cnt("t3_4", bus.ovf_count, 2'd3);
    tick(); check_state("t3_5", 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
    // Clear wins over a simultaneous event; status register still updates.
    bus.stat_clr = 1'b1;
    tick(); check_state("t3_clr", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    bus.stat_clr = 1'b0;
    bus.flag_we  = 1'b0;
    bus.br_en    = 1'b1;
    bus.br_cond  = BR_V;      #1 check_bit("t3_bv", bus.take_branch, 1'b1);

    // 4: undefined gin sets op_err and leaves flags/counter alone.
    bus.br_en   = 1'b0;
    bus.flag_we = 1'b1;
    bus.gin     = 3'b100;
    bus.zout    = 1'b1;
    bus.nout    = 1'b1;
    bus.vout    = 1'b1;
    tick(); check_state("t4_bad", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    idle();
    bus.stat_clr = 1'b1;
    tick(); check_state("t4_clr", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);

    // 5: bubble with flag write, overflow and always-branch does nothing.
    idle();
    bus.flag_we = 1'b1;
    bus.gin     = ALU_SUB;
    bus.zout    = 1'b1;
    bus.vout    = 1'b1;
    bus.br_en   = 1'b1;
    bus.br_cond = BR_ALWAYS;
    #1 check_bit("t5_take", bus.take_branch, 1'b0);
    tick(); check_state("t5", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);

    // 6: build up state, then reset against a pending event and branch.
    idle();
    bus.instr_valid = 1'b1;
    bus.flag_we     = 1'b1;
    bus.gin         = ALU_SUB;
    bus.zout        = 1'b1;
    bus.nout        = 1'b1;
    bus.vout        = 1'b1;
    tick();
    tick();
    bus.gin = 3'b101;
    tick(); check_state("t6_pre", 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1);
    bus.gin     = ALU_ADD;
    bus.br_en   = 1'b1;
    bus.br_cond = BR_ALWAYS;
    reset       = 1'b1;
    #1 check_bit("t6_take_rst", bus.take_branch, 1'b0);
    tick(); check_state("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    #1 check_bit("t6_take_post", bus.take_branch, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
